// File: rtl/axi_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_pkg
//  Description : Shared types and constants for the two-master read-channel
//                arbiter: FSM state encoding, AXI response codes and default
//                widths.
//  Contents    : state_t (S_IDLE/S_AR/S_R), c_resp_okay, c_resp_slverr,
//                c_addr_width, c_data_width, c_len_width
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_rd_pkg;

  localparam int c_addr_width = 32;
  localparam int c_data_width = 64;
  localparam int c_len_width  = 8;

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way request arbiter. Round-robin between req[0] and
//                req[1] using a last-grant register; with the build macro
//                ARB_DCACHE_PRIO_EN defined, req[1] always wins contention
//                and no history is kept.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                en            - arbitration allowed this cycle
//                req[1:0]      - requests (bit 1 = dcache, bit 0 = icache)
//                grant[1:0]    - one-hot (or zero) grant, combinational
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef ARB_DCACHE_PRIO_EN

  // Fixed priority needs no state; clk/rst are kept on the port list so the
  // instantiation is identical in both builds.
  logic w_unused_prio;
  assign w_unused_prio = clk ^ rst;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[1]) begin
        grant = 2'b10;
      end else if (req[0]) begin
        grant = 2'b01;
      end
    end
  end

`else

  // Index of the requester granted most recently. Reset to 1 so that the
  // icache wins the first contention.
  logic r_last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (|grant) begin
      // A grant is only ever issued together with the ready handshake, so
      // any non-zero grant marks an accepted request.
      r_last_grant <= grant[1];
    end
  end

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

`endif

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_arbiter
//  Description : Shares one AXI-style read channel between the icache (m0)
//                and dcache (m1) refill ports. One transaction in flight at
//                a time; bursts are routed back to the granted requester.
//                Build macro ARB_DCACHE_PRIO_EN selects fixed dcache priority
//                instead of round-robin.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                mX_ar_valid_i/_ready_o/_addr_i/_len_i - requester address
//                mX_r_valid_o/_ready_i/_resp_o/_data_o/_last_o - read data
//                s_ar_valid_o/_ready_i/_addr_o/_len_o  - downstream address
//                s_r_valid_i/_ready_o/_resp_i/_data_i/_last_i - downstream data
//                err_o - sticky flag: burst length and last disagreed
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter
  import axi_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = c_addr_width,
  parameter int DATA_WIDTH = c_data_width,
  parameter int LEN_WIDTH  = c_len_width
) (
  input  logic                  clk,
  input  logic                  rst,
  // icache refill port
  input  logic                  m0_ar_valid_i,
  output logic                  m0_ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] m0_ar_addr_i,
  input  logic [LEN_WIDTH-1:0]  m0_ar_len_i,
  output logic                  m0_r_valid_o,
  input  logic                  m0_r_ready_i,
  output logic [1:0]            m0_r_resp_o,
  output logic [DATA_WIDTH-1:0] m0_r_data_o,
  output logic                  m0_r_last_o,
  // dcache refill port
  input  logic                  m1_ar_valid_i,
  output logic                  m1_ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] m1_ar_addr_i,
  input  logic [LEN_WIDTH-1:0]  m1_ar_len_i,
  output logic                  m1_r_valid_o,
  input  logic                  m1_r_ready_i,
  output logic [1:0]            m1_r_resp_o,
  output logic [DATA_WIDTH-1:0] m1_r_data_o,
  output logic                  m1_r_last_o,
  // memory side
  output logic                  s_ar_valid_o,
  input  logic                  s_ar_ready_i,
  output logic [ADDR_WIDTH-1:0] s_ar_addr_o,
  output logic [LEN_WIDTH-1:0]  s_ar_len_o,
  input  logic                  s_r_valid_i,
  output logic                  s_r_ready_o,
  input  logic [1:0]            s_r_resp_i,
  input  logic [DATA_WIDTH-1:0] s_r_data_i,
  input  logic                  s_r_last_i,
  output logic                  err_o
);

  localparam logic [LEN_WIDTH-1:0] c_cnt_one = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_gnt;        // 1 = dcache owns the transaction
  logic                  r_ar_valid;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [LEN_WIDTH-1:0]  r_ar_len;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic                  r_err;

  logic [1:0]            w_grant;
  logic                  w_arb_en;
  logic                  w_ar_hs;
  logic                  w_in_r;
  logic                  w_beat;
  logic                  w_cnt_hit;
  logic                  w_last;
  logic                  w_done;
  logic                  w_len_err;

  // --------------------------------------------------------------------------
  // Arbitration: only while idle, and never during reset so that nothing is
  // accepted in a cycle the state is being cleared.
  // --------------------------------------------------------------------------
  assign w_arb_en = (r_state == S_IDLE) & ~rst;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (w_arb_en),
    .req   ({m1_ar_valid_i, m0_ar_valid_i}),
    .grant (w_grant)
  );

  assign m0_ar_ready_o = w_grant[0];
  assign m1_ar_ready_o = w_grant[1];
  assign w_ar_hs       = |w_grant;

  // --------------------------------------------------------------------------
  // Beat tracking. A beat completes the burst when either the memory flags
  // last or the expected count is reached; disagreement between the two is
  // recorded but the burst still ends so the channel cannot lock up.
  // --------------------------------------------------------------------------
  assign w_in_r      = (r_state == S_R);
  assign s_r_ready_o = w_in_r & (r_gnt ? m1_r_ready_i : m0_r_ready_i);
  assign w_beat      = s_r_valid_i & s_r_ready_o;
  assign w_cnt_hit   = (r_beat_cnt == r_ar_len);
  assign w_last      = s_r_last_i | w_cnt_hit;
  assign w_done      = w_beat & w_last;
  assign w_len_err   = w_beat & (s_r_last_i ^ w_cnt_hit);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ar_hs)                   w_state_nxt = S_AR;
      S_AR:    if (r_ar_valid & s_ar_ready_i) w_state_nxt = S_R;
      S_R:     if (w_done)                    w_state_nxt = S_IDLE;
      default:                                w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture, downstream address channel, beat counter, error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt      <= 1'b0;
      r_ar_valid <= 1'b0;
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_gnt      <= w_grant[1];
        r_ar_addr  <= w_grant[1] ? m1_ar_addr_i : m0_ar_addr_i;
        r_ar_len   <= w_grant[1] ? m1_ar_len_i  : m0_ar_len_i;
        r_ar_valid <= 1'b1;
        r_beat_cnt <= '0;
      end else begin
        if (r_ar_valid & s_ar_ready_i) begin
          r_ar_valid <= 1'b0;
        end
        if (w_beat) begin
          r_beat_cnt <= r_beat_cnt + c_cnt_one;
        end
      end
      if (w_len_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign s_ar_valid_o = r_ar_valid;
  assign s_ar_addr_o  = r_ar_addr;
  assign s_ar_len_o   = r_ar_len;
  assign err_o        = r_err;

  // --------------------------------------------------------------------------
  // Read data routing: the owner sees the downstream beat (with last forced
  // on the completing beat); the other requester sees all zeros.
  // --------------------------------------------------------------------------
  always_comb begin
    m0_r_valid_o = 1'b0;
    m0_r_resp_o  = 2'b00;
    m0_r_data_o  = '0;
    m0_r_last_o  = 1'b0;
    m1_r_valid_o = 1'b0;
    m1_r_resp_o  = 2'b00;
    m1_r_data_o  = '0;
    m1_r_last_o  = 1'b0;
    if (w_in_r) begin
      if (r_gnt) begin
        m1_r_valid_o = s_r_valid_i;
        m1_r_resp_o  = s_r_resp_i;
        m1_r_data_o  = s_r_data_i;
        m1_r_last_o  = w_last;
      end else begin
        m0_r_valid_o = s_r_valid_i;
        m0_r_resp_o  = s_r_resp_i;
        m0_r_data_o  = s_r_data_i;
        m0_r_last_o  = w_last;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_rd_arbiter
//  Description : Self-checking bench for axi_rd_arbiter. A table of directed
//                transactions, hand-written reset sequences and randomized
//                transactions judged against a transaction-level model of
//                the arbitration and burst-termination rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;
  import axi_rd_pkg::*;

`ifdef ARB_DCACHE_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        m0_ar_valid, m0_ar_ready_o, m0_r_valid_o, m0_r_ready, m0_r_last_o;
  logic [31:0] m0_ar_addr;
  logic [7:0]  m0_ar_len;
  logic [1:0]  m0_r_resp_o;
  logic [63:0] m0_r_data_o;
  logic        m1_ar_valid, m1_ar_ready_o, m1_r_valid_o, m1_r_ready, m1_r_last_o;
  logic [31:0] m1_ar_addr;
  logic [7:0]  m1_ar_len;
  logic [1:0]  m1_r_resp_o;
  logic [63:0] m1_r_data_o;
  logic        s_ar_valid_o, s_ar_ready, s_r_valid, s_r_ready_o, s_r_last, err_o;
  logic [31:0] s_ar_addr_o;
  logic [7:0]  s_ar_len_o;
  logic [1:0]  s_r_resp;
  logic [63:0] s_r_data;

  axi_rd_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .m0_ar_valid_i (m0_ar_valid),
    .m0_ar_ready_o (m0_ar_ready_o),
    .m0_ar_addr_i  (m0_ar_addr),
    .m0_ar_len_i   (m0_ar_len),
    .m0_r_valid_o  (m0_r_valid_o),
    .m0_r_ready_i  (m0_r_ready),
    .m0_r_resp_o   (m0_r_resp_o),
    .m0_r_data_o   (m0_r_data_o),
    .m0_r_last_o   (m0_r_last_o),
    .m1_ar_valid_i (m1_ar_valid),
    .m1_ar_ready_o (m1_ar_ready_o),
    .m1_ar_addr_i  (m1_ar_addr),
    .m1_ar_len_i   (m1_ar_len),
    .m1_r_valid_o  (m1_r_valid_o),
    .m1_r_ready_i  (m1_r_ready),
    .m1_r_resp_o   (m1_r_resp_o),
    .m1_r_data_o   (m1_r_data_o),
    .m1_r_last_o   (m1_r_last_o),
    .s_ar_valid_o  (s_ar_valid_o),
    .s_ar_ready_i  (s_ar_ready),
    .s_ar_addr_o   (s_ar_addr_o),
    .s_ar_len_o    (s_ar_len_o),
    .s_r_valid_i   (s_r_valid),
    .s_r_ready_o   (s_r_ready_o),
    .s_r_resp_i    (s_r_resp),
    .s_r_data_i    (s_r_data),
    .s_r_last_i    (s_r_last),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_prev;   // model: index of last granted requester
  bit m_err;    // model: sticky error

  typedef struct {
    bit          req0;
    bit          req1;
    logic [31:0] addr;
    logic [7:0]  len;
    int          ar_stall;
    int          last_at;   // beat index with s_r_last=1, -1 = never
    bit          rgap;
    bit          rstall;
    bit          fix_d0;
    logic [63:0] d0;
    int          exp_g;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_ar_valid = 0; m0_ar_addr = '0; m0_ar_len = '0; m0_r_ready = 0;
    m1_ar_valid = 0; m1_ar_addr = '0; m1_ar_len = '0; m1_r_ready = 0;
    s_ar_ready = 0; s_r_valid = 0; s_r_resp = '0; s_r_data = '0; s_r_last = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ar_ready"}, {m1_ar_ready_o, m0_ar_ready_o}, 0);
    chk({tag, "_r_valid"}, {m1_r_valid_o, m0_r_valid_o}, 0);
    chk({tag, "_r_last"}, {m1_r_last_o, m0_r_last_o}, 0);
    chk({tag, "_r_data"}, m0_r_data_o | m1_r_data_o, 0);
    chk({tag, "_s_ar_valid"}, s_ar_valid_o, 0);
    chk({tag, "_s_ar_addr"}, s_ar_addr_o, 0);
    chk({tag, "_s_ar_len"}, s_ar_len_o, 0);
    chk({tag, "_s_r_ready"}, s_r_ready_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    m_prev = 1;
    m_err  = 0;
    #1;
    chk_all_zero("reset");
  endtask

  task automatic set_rdy(input int g, input bit v);
    if (g == 1) m1_r_ready = v;
    else        m0_r_ready = v;
  endtask

  function automatic int model_pick(input bit r0, input bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (PRIO) return 1;
    return (m_prev == 0) ? 1 : 0;
  endfunction

  // One complete transaction, driven and checked cycle by cycle.
  task automatic txn(input vec_t v);
    logic [31:0] exp_addr;
    logic [63:0] dat;
    logic [1:0]  rsp;
    bit          exp_last;
    int          kend;
    int          g;
    g        = v.exp_g;
    exp_addr = (g == 1) ? v.addr + 32'h100 : v.addr;
    kend     = (v.last_at >= 0 && v.last_at < int'(v.len)) ? v.last_at : int'(v.len);

    m0_ar_valid = v.req0; m0_ar_addr = v.addr;          m0_ar_len = v.len;
    m1_ar_valid = v.req1; m1_ar_addr = v.addr + 32'h100; m1_ar_len = v.len;
    s_r_valid = 0; s_ar_ready = 0;
    #1;
    chk("ar_ready_m0", m0_ar_ready_o, (g == 0));
    chk("ar_ready_m1", m1_ar_ready_o, (g == 1));
    tick();
    // Keep both requesters asking with junk to prove no grant while busy.
    m0_ar_valid = 1; m0_ar_addr = $urandom; m0_ar_len = 8'($urandom);
    m1_ar_valid = 1; m1_ar_addr = $urandom; m1_ar_len = 8'($urandom);
    #1;
    chk("busy_ar_ready", {m1_ar_ready_o, m0_ar_ready_o}, 0);
    chk("s_ar_valid", s_ar_valid_o, 1);
    chk("s_ar_addr", s_ar_addr_o, exp_addr);
    chk("s_ar_len", s_ar_len_o, v.len);
    for (int i = 0; i < v.ar_stall; i++) begin
      tick();
      chk("s_ar_valid_hold", s_ar_valid_o, 1);
      chk("s_ar_addr_hold", s_ar_addr_o, exp_addr);
    end
    s_ar_ready = 1;
    tick();
    s_ar_ready = 0;
    #1;
    chk("s_ar_valid_drop", s_ar_valid_o, 0);

    for (int k = 0; k <= kend; k++) begin
      if (v.rgap && (k % 2 == 1)) begin
        s_r_valid = 0;
        set_rdy(g, 1);
        #1;
        chk("r_valid_gap", (g == 1) ? m1_r_valid_o : m0_r_valid_o, 0);
        tick();
      end
      dat = (v.fix_d0 && k == 0) ? v.d0 : {$urandom, $urandom};
      rsp = ($urandom_range(0, 1) == 1) ? c_resp_slverr : c_resp_okay;
      s_r_valid = 1; s_r_data = dat; s_r_resp = rsp; s_r_last = (k == v.last_at);
      exp_last  = (k == v.last_at) || (k == int'(v.len));
      if (v.rstall && k == 1) begin
        set_rdy(g, 0);
        set_rdy(1 - g, 1);
        #1;
        chk("r_ready_stall", s_r_ready_o, 0);
        chk("r_valid_stall", (g == 1) ? m1_r_valid_o : m0_r_valid_o, 1);
        tick();
      end
      set_rdy(g, 1);
      set_rdy(1 - g, 1'($urandom_range(0, 1)));
      #1;
      chk("r_valid", (g == 1) ? m1_r_valid_o : m0_r_valid_o, 1);
      chk("r_data", (g == 1) ? m1_r_data_o : m0_r_data_o, dat);
      chk("r_resp", (g == 1) ? m1_r_resp_o : m0_r_resp_o, rsp);
      chk("r_last", (g == 1) ? m1_r_last_o : m0_r_last_o, exp_last);
      chk("other_r_valid", (g == 1) ? m0_r_valid_o : m1_r_valid_o, 0);
      chk("other_r_data", (g == 1) ? m0_r_data_o : m1_r_data_o, 0);
      chk("s_r_ready", s_r_ready_o, 1);
      chk("busy_ar_ready_r", {m1_ar_ready_o, m0_ar_ready_o}, 0);
      tick();
    end

    // The burst must be over: further beats are not accepted.
    m0_ar_valid = 0; m1_ar_valid = 0;
    s_r_valid = 1; s_r_last = 0; m0_r_ready = 1; m1_r_ready = 1;
    #1;
    chk("end_s_r_ready", s_r_ready_o, 0);
    chk("end_r_valid", {m1_r_valid_o, m0_r_valid_o}, 0);
    chk("err", err_o, v.exp_err);
    s_r_valid = 0; m0_r_ready = 0; m1_r_ready = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Contention right after reset, then directed corner cases.
    for (int i = 0; i < 4; i++)
      vecs[i] = '{1, 1, 32'h0000_1000 + 32'(i) * 32'h40, 8'd0, 0, 0, 0, 0, 0, 64'd0,
                  PRIO ? 1 : (i % 2), 0};
    vecs[4] = '{1, 0, 32'h8000_0008, 8'd0, 0, 0, 0, 0, 1, 64'h1122_3344_5566_7788, 0, 0};
    vecs[5] = '{0, 1, 32'h0000_2000, 8'd3, 2, 3, 1, 1, 0, 64'd0, 1, 0};
    vecs[6] = '{1, 0, 32'h0000_3000, 8'd3, 0, 1, 0, 0, 0, 64'd0, 0, 1};
    vecs[7] = '{0, 1, 32'h0000_4000, 8'd0, 0, 0, 0, 0, 0, 64'd0, 1, 1};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      txn(vecs[i]);
      m_prev = vecs[i].exp_g;
      m_err  = vecs[i].exp_err;
    end

    // Reset in the middle of an icache burst.
    m0_ar_valid = 1; m0_ar_addr = 32'h0000_5000; m0_ar_len = 8'd3;
    #1;
    chk("mid_ar_ready", m0_ar_ready_o, 1);
    tick();
    m0_ar_valid = 0;
    s_ar_ready = 1;
    tick();
    s_ar_ready = 0;
    s_r_valid = 1; s_r_data = 64'hDEAD_BEEF_0000_0001; s_r_last = 0; m0_r_ready = 1;
    tick();
    chk("mid_r_valid", m0_r_valid_o, 1);
    rst = 1;
    tick();
    rst = 0;
    s_r_valid = 0; m0_r_ready = 0;
    m_prev = 1; m_err = 0;
    #1;
    chk_all_zero("midrst");
    // New dcache request is granted in the first idle cycle after reset.
    txn('{0, 1, 32'h0000_6000, 8'd1, 1, 1, 0, 0, 0, 64'd0, 1, 0});
    m_prev = 1;

    // Memory never flags last on a two-beat burst.
    txn('{1, 0, 32'h0000_7000, 8'd1, 0, -1, 0, 0, 0, 64'd0, 0, 1});
    m_prev = 0; m_err = 1;

    // Randomized transactions against the model.
    for (int n = 0; n < 40; n++) begin
      int r;
      if ($urandom_range(0, 2) == 0) do_reset();
      rv.req0 = 1'($urandom_range(0, 1));
      rv.req1 = 1'($urandom_range(0, 1));
      if (!rv.req0 && !rv.req1) rv.req0 = 1;
      rv.addr     = $urandom & 32'hFFFF_FFF8;
      rv.len      = 8'($urandom_range(0, 5));
      rv.ar_stall = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r < 7)                       rv.last_at = int'(rv.len);
      else if (r < 9 && rv.len > 0)    rv.last_at = $urandom_range(0, int'(rv.len) - 1);
      else                             rv.last_at = -1;
      rv.rgap    = 1'($urandom_range(0, 1));
      rv.rstall  = 1'($urandom_range(0, 1));
      rv.fix_d0  = 0;
      rv.d0      = '0;
      rv.exp_g   = model_pick(rv.req0, rv.req1);
      rv.exp_err = m_err | (rv.last_at != int'(rv.len));
      txn(rv);
      m_prev = rv.exp_g;
      m_err  = rv.exp_err;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
